// File: rtl/store_align_buffer.sv
// Store alignment and 2-entry write buffer between the memory stage and the data memory write port.
// Optional build macro STORE_MISALIGN_TRAP_EN: reject misaligned stores and pulse MisalignedStore.
module store_align_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        StoreValid,
  output logic        StoreReady,
  input  logic [31:0] StoreAddr,
  input  logic [31:0] StoreData,
  input  logic [2:0]  WidthSrc,
  output logic        MemWriteEn,
  input  logic        MemReady,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWriteData,
  output logic [3:0]  MemByteEn,
  output logic        BufferEmpty,
  output logic        MisalignedStore
);

  // state | meaning
  // EMPTY | no pending stores
  // ONE   | one entry pending at headPtr
  // FULL  | both entries pending, stores back-pressured
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occState_t;

  occState_t   state, nextState;
  logic [29:0] entryAddr [2];
  logic [31:0] entryData [2];
  logic [3:0]  entryBe   [2];
  logic        headPtr, tailPtr;

  logic [1:0]  off, effOff;
  logic        isByte, isHalf, isReserved;
  logic [31:0] alignData;
  logic [3:0]  alignBe;
  logic        offerOk, doPush, doPop;
  logic        unusedWidthBit;

  assign unusedWidthBit = WidthSrc[2];

  // Offsets are forced down for misaligned halfwords/words; with the trap
  // enabled those stores never get pushed, so the forcing is harmless there.
  always_comb begin
    off        = StoreAddr[1:0];
    isByte     = (WidthSrc[1:0] == 2'b10);
    isHalf     = (WidthSrc[1:0] == 2'b01);
    isReserved = (WidthSrc[1:0] == 2'b11);
    effOff     = 2'b00;
    alignData  = StoreData;
    alignBe    = 4'b1111;
    if (isByte) begin
      effOff    = off;
      alignData = {4{StoreData[7:0]}};
      alignBe   = 4'b0001 << effOff;
    end else if (isHalf) begin
      effOff    = {off[1], 1'b0};
      alignData = {2{StoreData[15:0]}};
      alignBe   = 4'b0011 << effOff;
    end
  end

  assign StoreReady  = (state != FULL);
  assign MemWriteEn  = (state != EMPTY);
  assign BufferEmpty = (state == EMPTY);
  assign offerOk     = StoreValid && StoreReady && !isReserved;
  assign doPop       = MemWriteEn && MemReady;

`ifdef STORE_MISALIGN_TRAP_EN
  logic isMisaligned;
  logic misFlag;

  assign isMisaligned = (isHalf && off[0]) || ((WidthSrc[1:0] == 2'b00) && (off != 2'b00));
  assign doPush       = offerOk && !isMisaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) misFlag <= 1'b0;
    else       misFlag <= offerOk && isMisaligned;
  end

  assign MisalignedStore = misFlag;
`else
  assign doPush          = offerOk;
  assign MisalignedStore = 1'b0;
`endif

  always_comb begin
    nextState = state;
    unique case (state)
      EMPTY: if (doPush) nextState = ONE;
      ONE: begin
        if (doPush && !doPop)      nextState = FULL;
        else if (doPop && !doPush) nextState = EMPTY;
      end
      FULL:    if (doPop) nextState = ONE;
      default: nextState = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      headPtr <= 1'b0;
      tailPtr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        entryAddr[i] <= '0;
        entryData[i] <= '0;
        entryBe[i]   <= '0;
      end
    end else begin
      state <= nextState;
      if (doPush) begin
        entryAddr[tailPtr] <= StoreAddr[31:2];
        entryData[tailPtr] <= alignData;
        entryBe[tailPtr]   <= alignBe;
        tailPtr            <= ~tailPtr;
      end
      if (doPop) headPtr <= ~headPtr;
    end
  end

  assign MemAddr      = MemWriteEn ? {entryAddr[headPtr], 2'b00} : 32'h0;
  assign MemWriteData = MemWriteEn ? entryData[headPtr] : 32'h0;
  assign MemByteEn    = MemWriteEn ? entryBe[headPtr] : 4'h0;

endmodule

// File: doc/store_align_buffer.md
# store_align_buffer

Store-side counterpart of the load reduce unit: takes a raw register store value, width code and byte address from the memory stage, aligns the data into the correct byte lanes with matching byte enables, and queues it in a 2-entry write buffer that drains to data memory over a valid/ready handshake. It sits between the pipeline's memory stage and the data memory write port.

## Interface
- No parameters; depth fixed at 2 entries, data/address width fixed at 32.
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- StoreValid  input  1  memory stage presents a store this cycle
- StoreReady  output  1  buffer can accept a store this cycle
- StoreAddr  input  32  byte address of store
- StoreData  input  32  unaligned store value (valid data in low bits)
- WidthSrc  input  3  width code: [1:0] 00 word, 01 halfword, 10 byte, 11 reserved; [2] ignored
- MemWriteEn  output  1  head entry valid, write requested
- MemReady  input  1  memory accepts head entry this cycle
- MemAddr  output  32  word-aligned address of head entry ({addr[31:2],2'b00})
- MemWriteData  output  32  lane-aligned write data of head entry
- MemByteEn  output  4  byte enables of head entry
- BufferEmpty  output  1  no pending stores (used for fence/drain)
- MisalignedStore  output  1  one-cycle pulse: last offered store was rejected as misaligned

## Operation
- Push: StoreValid && StoreReady at rising edge. Pop: MemWriteEn && MemReady at rising edge.
- Alignment (off = StoreAddr[1:0]):
  - byte: MemWriteData = {4{StoreData[7:0]}}, MemByteEn = 4'b0001 << off.
  - halfword: data = {2{StoreData[15:0]}}, byte enable = 4'b0011 << off (off 0 or 2).
  - word: data = StoreData, byte enable = 4'b1111.
  - reserved code 11: store is dropped, no push, no MisalignedStore pulse.
- Misaligned = halfword with off[0]=1, or word with off!=0; handling set by Configuration.
- FSM on occupancy: EMPTY -> ONE on push; ONE -> FULL on push without pop; ONE -> EMPTY on pop without push; ONE stays ONE on simultaneous push+pop; FULL -> ONE on pop. Push is impossible in FULL.
- StoreReady = (state != FULL), combinational from state only; no pass-through when FULL with a same-cycle pop.
- FIFO order strict: entries drain in push order; head pointer wraps 1 -> 0.
- MemAddr/MemWriteData/MemByteEn show the head entry while MemWriteEn=1, all zero while EMPTY.
- BufferEmpty = (state == EMPTY).

## Timing
- Reset (asynchronous): state EMPTY, pointers 0, entries cleared. Outputs: StoreReady 1, MemWriteEn 0, MemAddr 0, MemWriteData 0, MemByteEn 0, BufferEmpty 1, MisalignedStore 0.
- Reset mid-operation discards all pending entries; no write completes after reset asserts.
- Latency: store pushed at edge N appears on MemWriteEn at N+1 (if buffer was empty); no combinational StoreData->MemWriteData path.
- MemWriteEn stays high and head outputs stay stable until a pop; MemReady low stalls indefinitely.
- MisalignedStore is registered: asserts for exactly the cycle after the offending StoreValid edge.
- StoreValid while StoreReady=0: ignored, not pushed, no flag; the memory stage holds it.

## Configuration
- STORE_MISALIGN_TRAP_EN defined: misaligned store is not pushed and MisalignedStore pulses for one cycle; the store is still considered consumed (requires StoreReady=1).
- Not defined: misaligned stores are pushed with off forced down (halfword off&2'b10, word off=0); MisalignedStore tied to 0.

## Test plan
- Byte store addr 0x1003, data 0x000000AB, MemReady=1 -> next cycle MemWriteEn=1, MemAddr 0x1000, MemWriteData 0xABABABAB, MemByteEn 4'b1000; BufferEmpty returns 1 one cycle later.
- Halfword addr 0x2002 data 0x1234, word addr 0x2004 data 0xDEADBEEF, MemReady=0 -> StoreReady drops to 0 after 2nd push; then MemReady=1 drains 0x12341234/4'b1100 then 0xDEADBEEF/4'b1111 in order.
- Occupancy ONE, simultaneous push and pop -> state remains ONE, StoreReady stays 1, correct entry order across pointer wrap.
- Word store addr 0x3001: with STORE_MISALIGN_TRAP_EN -> MisalignedStore=1 one cycle, no MemWriteEn; without -> write to 0x3000, MemByteEn 4'b1111.
- Two stores buffered with MemReady=0, reset asserted asynchronously mid-cycle -> outputs immediately reset values, no memory write after MemReady rises.
- WidthSrc=3'b111 store -> dropped, BufferEmpty stays 1, no flag.
